// File: rtl/cic_sched_pkg.sv
// Shared defaults and helpers for the time-shared CIC first-stage scheduler.
package cic_sched_pkg;

  localparam int N_CHAN_DEF    = 4;
  localparam int IN_WIDTH_DEF  = 16;
  localparam int OUT_WIDTH_DEF = 18;
  localparam int CIC_N_DEF     = 4;

  // Ceiling log2, never below 1 so index/count vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  localparam int CNT_W = clog2(CIC_N_DEF);

endpackage

// File: rtl/cic_chan_sched_rr_arbiter.sv
// Purely combinational round-robin arbiter: first requester at or above ptr,
// wrapping around. The pointer register belongs to the caller.
module rr_arbiter
  import cic_sched_pkg::*;
#(
  parameter int n = 4,
  parameter int w = clog2(n)
) (
  input  logic [n-1:0] req,
  input  logic [w-1:0] ptr,
  output logic [n-1:0] gnt,
  output logic [w-1:0] gnt_idx,
  output logic         gnt_valid
);

  int idx;

  // Scan upward from ptr; the first pending request wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < n; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = w'(idx);
      end
    end
  end

endmodule

// File: rtl/cic_chan_sched.sv
// Time-shared CIC first stage (integrator, decimation counter, comb) serving
// n_chan gated streams with one adder and one subtractor.
// Optional: define CIC_SCHED_OVF_EN to build the sticky dropped-sample flags;
// otherwise ovf is tied to 0 and ovf_clr is ignored.
module cic_chan_sched
  import cic_sched_pkg::*;
#(
  parameter int n_chan    = N_CHAN_DEF,
  parameter int cw        = clog2(n_chan),
  parameter int in_width  = IN_WIDTH_DEF,
  parameter int out_width = OUT_WIDTH_DEF,
  parameter int cic_n     = CIC_N_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [n_chan-1:0]           g_in,
  input  logic [n_chan*in_width-1:0]  d_in,
  input  logic                        ovf_clr,
  output logic                        g_out,
  output logic [cw-1:0]               ch_out,
  output logic signed [out_width-1:0] d_out,
  output logic [n_chan-1:0]           ovf
);

  localparam int cnt_w = clog2(cic_n);

  logic [n_chan-1:0]           pend;
  logic [in_width-1:0]         pend_data [n_chan];
  logic signed [out_width-1:0] integ     [n_chan];
  logic signed [out_width-1:0] prev      [n_chan];
  logic [cnt_w-1:0]            cnt       [n_chan];
  logic [cw-1:0]               rr_ptr;

  logic [n_chan-1:0]           gnt;
  logic [cw-1:0]               gnt_idx;
  logic                        gnt_valid;

  logic signed [out_width-1:0] sample_ext;
  logic signed [out_width-1:0] int_sum;

  logic                        dump;
  logic [cw-1:0]               dump_ch;
  logic signed [out_width-1:0] dump_int;

  rr_arbiter #(
    .n (n_chan),
    .w (cw)
  ) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Shared integrator adder, fed by the granted channel's pending sample.
  assign sample_ext = {{(out_width-in_width){pend_data[gnt_idx][in_width-1]}},
                       pend_data[gnt_idx]};
  assign int_sum    = integ[gnt_idx] + sample_ext;

  // Capture: accept a new sample when the slot is free or being drained now.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= '0;
      for (int i = 0; i < n_chan; i++) pend_data[i] <= '0;
    end else begin
      for (int i = 0; i < n_chan; i++) begin
        if (g_in[i] && (!pend[i] || gnt[i])) begin
          pend_data[i] <= d_in[i*in_width +: in_width];
          pend[i]      <= 1'b1;
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner; holds when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      rr_ptr <= (gnt_idx == cw'(n_chan-1)) ? '0 : gnt_idx + cw'(1);
    end
  end

  // Integrate the granted channel and flag a dump on its decimation boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < n_chan; i++) begin
        integ[i] <= '0;
        cnt[i]   <= '0;
      end
      dump     <= 1'b0;
      dump_ch  <= '0;
      dump_int <= '0;
    end else begin
      dump <= 1'b0;
      if (gnt_valid) begin
        integ[gnt_idx] <= int_sum;
        if (cnt[gnt_idx] == cnt_w'(cic_n-1)) begin
          cnt[gnt_idx] <= '0;
          dump         <= 1'b1;
          dump_ch      <= gnt_idx;
          dump_int     <= int_sum;
        end else begin
          cnt[gnt_idx] <= cnt[gnt_idx] + cnt_w'(1);
        end
      end
    end
  end

  // Comb: difference against the channel's previous dumped integrator value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < n_chan; i++) prev[i] <= '0;
      g_out  <= 1'b0;
      ch_out <= '0;
      d_out  <= '0;
    end else begin
      g_out <= dump;
      if (dump) begin
        d_out         <= dump_int - prev[dump_ch];
        prev[dump_ch] <= dump_int;
        ch_out        <= dump_ch;
      end
    end
  end

`ifdef CIC_SCHED_OVF_EN
  logic [n_chan-1:0] ovf_q;
  logic [n_chan-1:0] drop;

  assign drop = g_in & pend & ~gnt;

  // Sticky drop flags; a drop in the clearing cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clr ? '0 : ovf_q) | drop;
    end
  end

  assign ovf = ovf_q;
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = ovf_clr;
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_cic_chan_sched.sv
// Directed self-checking bench for cic_chan_sched (4 channels, decimate by 4).
module tb_cic_chan_sched;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int OW = 18;
  localparam int CW = 2;

`ifdef CIC_SCHED_OVF_EN
  localparam logic [N-1:0] OVF_MASK = 4'b1111;
`else
  localparam logic [N-1:0] OVF_MASK = 4'b0000;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0]         g_in = '0;
  logic [N*IW-1:0]      d_in = '0;
  logic                 ovf_clr = 1'b0;
  logic                 g_out;
  logic [CW-1:0]        ch_out;
  logic signed [OW-1:0] d_out;
  logic [N-1:0]         ovf;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int ch;
    int d;
  } ev_t;

  ev_t evq[$];

  cic_chan_sched #(
    .n_chan    (N),
    .cw        (CW),
    .in_width  (IW),
    .out_width (OW),
    .cic_n     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .g_in    (g_in),
    .d_in    (d_in),
    .ovf_clr (ovf_clr),
    .g_out   (g_out),
    .ch_out  (ch_out),
    .d_out   (d_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (g_out === 1'b1) begin
      e.cyc = cyc;
      e.ch  = int'(ch_out);
      e.d   = int'(d_out);
      evq.push_back(e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_d(input int ch, input logic [IW-1:0] v);
    d_in[ch*IW +: IW] = v;
  endtask

  task automatic do_reset();
    g_in    = '0;
    ovf_clr = 1'b0;
    reset   = 1'b0;
    ticks(2);
    reset   = 1'b1;
    evq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ticks(2);
    n_total++; if (g_out !== 1'b0) $display("FAIL reset_g_out got=%0b exp=0", g_out); else n_pass++;
    n_total++; if (d_out !== '0) $display("FAIL reset_d_out got=%0d exp=0", d_out); else n_pass++;
    n_total++; if (ch_out !== '0) $display("FAIL reset_ch_out got=%0d exp=0", ch_out); else n_pass++;
    n_total++; if (ovf !== '0) $display("FAIL reset_ovf got=%b exp=0000", ovf); else n_pass++;
    reset = 1'b1;
    evq.delete();
  endtask

  task automatic test_single_chan();
    int s4;
    do_reset();
    set_d(0, 16'd1);
    s4 = 0;
    for (int k = 0; k < 12; k++) begin
      g_in = 4'b0001;
      tick();
      if (k == 3) s4 = cyc;
      g_in = '0;
      ticks(3);
    end
    ticks(4);
    n_total++; if (evq.size() !== 3) $display("FAIL single_count got=%0d exp=3", evq.size()); else n_pass++;
    if (evq.size() > 0) begin
      n_total++;
      if (evq[0].cyc !== s4 + 2) $display("FAIL single_latency got=%0d exp=%0d", evq[0].cyc, s4 + 2);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i < evq.size()) begin
        n_total++; if (evq[i].ch !== 0) $display("FAIL single_ch[%0d] got=%0d exp=0", i, evq[i].ch); else n_pass++;
        n_total++; if (evq[i].d !== 4) $display("FAIL single_d[%0d] got=%0d exp=4", i, evq[i].d); else n_pass++;
      end
    end
  endtask

  task automatic test_all_chan();
    int s4;
    do_reset();
    for (int c = 0; c < N; c++) set_d(c, 16'(c + 1));
    s4 = 0;
    for (int p = 0; p < 4; p++) begin
      g_in = 4'b1111;
      tick();
      if (p == 3) s4 = cyc;
      g_in = '0;
      ticks(3);
    end
    ticks(6);
    n_total++; if (evq.size() !== 4) $display("FAIL all_count got=%0d exp=4", evq.size()); else n_pass++;
    if (evq.size() > 0) begin
      n_total++;
      if (evq[0].cyc !== s4 + 2) $display("FAIL all_latency got=%0d exp=%0d", evq[0].cyc, s4 + 2);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i < evq.size()) begin
        n_total++; if (evq[i].ch !== i) $display("FAIL all_ch[%0d] got=%0d exp=%0d", i, evq[i].ch, i); else n_pass++;
        n_total++; if (evq[i].d !== 4*(i+1)) $display("FAIL all_d[%0d] got=%0d exp=%0d", i, evq[i].d, 4*(i+1)); else n_pass++;
        n_total++;
        if (evq[i].cyc !== evq[0].cyc + i) $display("FAIL all_consec[%0d] got=%0d exp=%0d", i, evq[i].cyc, evq[0].cyc + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ovf();
    do_reset();
    set_d(1, 16'd0);
    // One ch1 sample moves the pointer to 2, so ch3 is granted second.
    g_in = 4'b0010;
    tick();
    g_in = '0;
    ticks(3);
    g_in = 4'b1111;
    tick();
    g_in = 4'b1000;
    tick();
    n_total++; if (ovf !== (4'b1000 & OVF_MASK)) $display("FAIL ovf_refill got=%b exp=%b", ovf, 4'b1000 & OVF_MASK); else n_pass++;
    g_in = 4'b1000; ovf_clr = 1'b1;
    tick();
    n_total++; if (ovf !== 4'b0000) $display("FAIL ovf_grant_refill got=%b exp=0000", ovf); else n_pass++;
    g_in = 4'b1000; ovf_clr = 1'b1;
    tick();
    n_total++; if (ovf !== (4'b1000 & OVF_MASK)) $display("FAIL ovf_set_wins got=%b exp=%b", ovf, 4'b1000 & OVF_MASK); else n_pass++;
    g_in = '0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_total++; if (ovf !== 4'b0000) $display("FAIL ovf_clr got=%b exp=0000", ovf); else n_pass++;
    ticks(6);
  endtask

  task automatic test_neg_full();
    do_reset();
    set_d(1, 16'h8000);
    g_in = 4'b0010;
    ticks(16);
    g_in = '0;
    ticks(6);
    n_total++; if (evq.size() !== 4) $display("FAIL neg_count got=%0d exp=4", evq.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < evq.size()) begin
        n_total++; if (evq[i].ch !== 1) $display("FAIL neg_ch[%0d] got=%0d exp=1", i, evq[i].ch); else n_pass++;
        n_total++; if (evq[i].d !== -131072) $display("FAIL neg_d[%0d] got=%0d exp=-131072", i, evq[i].d); else n_pass++;
      end
    end
    n_total++; if (ovf !== 4'b0000) $display("FAIL neg_ovf got=%b exp=0000", ovf); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Starts from the previous test's state so d_out holds a nonzero value.
    set_d(0, 16'd1);
    g_in = 4'b0001;
    tick();
    g_in = '0;
    ticks(3);
    g_in = 4'b0001;
    tick();
    g_in = '0;
    tick();
    reset = 1'b0;
    tick();
    n_total++; if (g_out !== 1'b0) $display("FAIL mid_g_out got=%0b exp=0", g_out); else n_pass++;
    n_total++; if (d_out !== '0) $display("FAIL mid_d_out got=%0d exp=0", d_out); else n_pass++;
    n_total++; if (ovf !== '0) $display("FAIL mid_ovf got=%b exp=0000", ovf); else n_pass++;
    reset = 1'b1;
    evq.delete();
    for (int k = 0; k < 4; k++) begin
      g_in = 4'b0001;
      tick();
      g_in = '0;
      ticks(3);
    end
    ticks(4);
    n_total++; if (evq.size() !== 1) $display("FAIL mid_count got=%0d exp=1", evq.size()); else n_pass++;
    if (evq.size() > 0) begin
      n_total++; if (evq[0].ch !== 0) $display("FAIL mid_ch got=%0d exp=0", evq[0].ch); else n_pass++;
      n_total++; if (evq[0].d !== 4) $display("FAIL mid_d got=%0d exp=4", evq[0].d); else n_pass++;
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int c = 0; c < 3; c++) set_d(c, 16'd1);
    g_in = 4'b0111;
    ticks(36);
    g_in = '0;
    ticks(10);
    // Grants rotate 0,1,2 (3 skipped): 12 or 13 integrates each, 3 dumps each.
    n_total++; if (evq.size() !== 9) $display("FAIL cont_count got=%0d exp=9", evq.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      if (i < evq.size()) begin
        n_total++; if (evq[i].ch !== i % 3) $display("FAIL cont_ch[%0d] got=%0d exp=%0d", i, evq[i].ch, i % 3); else n_pass++;
        n_total++; if (evq[i].d !== 4) $display("FAIL cont_d[%0d] got=%0d exp=4", i, evq[i].d); else n_pass++;
      end
    end
    n_total++; if (ovf !== (4'b0111 & OVF_MASK)) $display("FAIL cont_ovf got=%b exp=%b", ovf, 4'b0111 & OVF_MASK); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_chan();
    test_all_chan();
    test_ovf();
    test_neg_full();
    test_reset_mid();
    test_contention();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
